// File: rtl/prince_ti_pkg.sv
// Shared definitions for the PRINCE threshold-implementation datapath.
// Holds state/share geometry and the skid-buffer state encoding.
package prince_ti_pkg;

  localparam int PRINCE_STATE_W = 64;
  localparam int NIBBLE_W       = 4;
  localparam int NUM_SHARES     = 3;

  // Occupancy of the two-entry skid buffer sitting in front of A5.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage : prince_ti_pkg

// File: rtl/prince_ti_share_refresh.sv
// Combinational 3-share refresh in front of the share register banks.
// Config macro: SHARE_REFRESH_EN -- when defined, two fresh random masks are
// folded into the shares so that their XOR is preserved; otherwise the shares
// pass through unchanged and rnd is ignored.
module prince_ti_share_refresh
  import prince_ti_pkg::*;
#(
  parameter int WIDTH = PRINCE_STATE_W
) (
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   x2,
  input  logic [WIDTH-1:0]   x3,
  input  logic [2*WIDTH-1:0] rnd,
  output logic [WIDTH-1:0]   s1,
  output logic [WIDTH-1:0]   s2,
  output logic [WIDTH-1:0]   s3
);

`ifdef SHARE_REFRESH_EN
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;

  assign r1 = rnd[WIDTH-1:0];
  assign r2 = rnd[2*WIDTH-1:WIDTH];

  // Each share only ever meets randomness, never another share; the third
  // share absorbs both masks so the XOR of all three is unchanged.
  assign s1 = x1 ^ r1;
  assign s2 = x2 ^ r2;
  assign s3 = x3 ^ r1 ^ r2;
`else
  // Randomness is not needed without refresh; sink it so it is visibly unused.
  logic unused_rnd;
  assign unused_rnd = ^rnd;

  assign s1 = x1;
  assign s2 = x2;
  assign s3 = x3;
`endif

endmodule : prince_ti_share_refresh

// File: rtl/prince_ti_share_pipe.sv
// 3-share register stage feeding the PRINCE TI A5 affine layer.
// Each share lives in its own main/skid flop bank (the glitch barrier before the
// next non-linear stage) and is presented through a valid/ready skid buffer.
// Config macro: SHARE_REFRESH_EN enables share refresh ahead of the banks.
module prince_ti_share_pipe
  import prince_ti_pkg::*;
#(
  parameter int WIDTH = PRINCE_STATE_W,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   x2,
  input  logic [WIDTH-1:0]   x3,
  input  logic [2*WIDTH-1:0] rnd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y1,
  output logic [WIDTH-1:0]   y2,
  output logic [WIDTH-1:0]   y3,
  output logic [CNT_W-1:0]   beat_cnt
);

  skid_state_e state_q;
  skid_state_e state_d;

  logic accept;
  logic emit;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] s_sh [NUM_SHARES];
  logic [WIDTH-1:0] y_sh [NUM_SHARES];

  // Handshake flags come straight from the state register, so in_ready never
  // has a combinational path from out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  prince_ti_share_refresh #(
    .WIDTH (WIDTH)
  ) u_refresh (
    .x1  (x1),
    .x2  (x2),
    .x3  (x3),
    .rnd (rnd),
    .s1  (s_sh[0]),
    .s2  (s_sh[1]),
    .s3  (s_sh[2])
  );

  // Skid-buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bank load strobes; flush wins over every other transition
  // and suppresses all loads, so a beat offered in that cycle is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b11: load_main_in = 1'b1;
            2'b10: begin
              state_d   = TWO;
              load_skid = 1'b1;
            end
            2'b01: state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        TWO: begin
          if (emit) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // One independent main/skid bank per share; no bank ever sees another share.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Main entry drives A5; skid entry catches the beat that arrives under stall.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: the data banks are reset on purpose: reset must clear y* and
      // leave no stale share material behind in either entry.
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main_in) begin
          main_q <= s_sh[i];
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= s_sh[i];
        end
      end
    end

    assign y_sh[i] = main_q;
  end

  assign y1 = y_sh[0];
  assign y2 = y_sh[1];
  assign y3 = y_sh[2];

  // Accepted-beat counter; a beat discarded by flush is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && !flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign beat_cnt = cnt_q;

endmodule : prince_ti_share_pipe

// File: tb/tb_prince_ti_share_pipe.sv
// Self-checking bench for prince_ti_share_pipe: directed scenarios plus random
// traffic compared against a queue-based model of the two-entry FIFO.
// Config macro: SHARE_REFRESH_EN (the model applies the refresh when defined).
module tb_prince_ti_share_pipe;

  localparam int W  = 64;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x1, x2, x3;
  logic [2*W-1:0] rnd;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y1, y2, y3;
  logic [CW-1:0]  beat_cnt;

  always #5 clk = ~clk;

  prince_ti_share_pipe #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .rnd       (rnd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .beat_cnt  (beat_cnt)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] xs;
  } beat_t;

  beat_t       q[$];
  int unsigned exp_cnt;
  int          n_vec;
  int          n_bad;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t make_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c, input logic [2*W-1:0] r);
    beat_t t;
    t.xs = a ^ b ^ c;
`ifdef SHARE_REFRESH_EN
    t.a = a ^ r[W-1:0];
    t.b = b ^ r[2*W-1:W];
    t.c = c ^ r[W-1:0] ^ r[2*W-1:W];
`else
    t.a = a;
    t.b = b;
    t.c = c;
    if (r != r) t.a = '0;
`endif
    return t;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [2*W-1:0] r,
                       input logic ordy, input logic fl);
    in_valid  = v;
    x1        = a;
    x2        = b;
    x3        = c;
    rnd       = r;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic drive_rand(input logic v, input logic ordy, input logic fl);
    drive(v, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, ordy, fl);
  endtask

  // Compare DUT outputs against the FIFO model (head of queue is what A5 sees).
  task automatic compare_outputs();
    check("in_ready", W'(in_ready), W'(q.size() < 2));
    check("out_valid", W'(out_valid), W'(q.size() > 0));
    check("beat_cnt", W'(beat_cnt), W'(exp_cnt & 32'hFF));
    if (q.size() > 0) begin
      check("y1", y1, q[0].a);
      check("y2", y2, q[0].b);
      check("y3", y3, q[0].c);
      check("share_xor", y1 ^ y2 ^ y3, q[0].xs);
    end
  endtask

  // One clock: check, then advance the model with the handshake the model predicts.
  task automatic cycle();
    logic acc;
    logic emt;
    compare_outputs();
    acc = in_valid && (q.size() < 2);
    emt = out_ready && (q.size() > 0);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) begin
        q.push_back(make_beat(x1, x2, x3, rnd));
        exp_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    int          gaps;
    int unsigned cnt_before;
    beat_t       nb;

    n_vec   = 0;
    n_bad   = 0;
    exp_cnt = 0;

    // Reset state.
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_y1", y1, 0);
    check("rst_y2", y2, 0);
    check("rst_y3", y3, 0);
    check("rst_cnt", W'(beat_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", W'(in_ready), 1);

    // Single beat, shares unchanged.
    drive(1'b1, 64'h0123456789ABCDEF, '0, '0, '0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("single_valid", W'(out_valid), 1);
    check("single_y1", y1, 64'h0123456789ABCDEF);
    check("single_y2", y2, 0);
    check("single_y3", y3, 0);
    check("single_cnt", W'(beat_cnt), 1);
    cycle();

    // Back-pressure: three offers, two fit.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b0, 1'b0);
      cycle();
    end
    check("bp_in_ready", W'(in_ready), 0);
    check("bp_out_valid", W'(out_valid), 1);
    check("bp_cnt", W'(beat_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1, 1'b0);
      cycle();
    end

    // Streaming with counter wrap; after the first beat there must be no gaps.
    gaps = 0;
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'b1, 1'b1, 1'b0);
      if (i > 0 && !out_valid) gaps++;
      cycle();
    end
    check("stream_gaps", W'(gaps), 0);
    check("stream_cnt", W'(beat_cnt), W'((3 + 300) % 256));
    drive_rand(1'b0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Flush while full with a beat offered.
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b0, 1'b0);
      cycle();
    end
    cnt_before = exp_cnt;
    drive_rand(1'b1, 1'b0, 1'b1);
    cycle();
    check("flush_out_valid", W'(out_valid), 0);
    check("flush_cnt", W'(beat_cnt), W'(cnt_before & 32'hFF));
    drive_rand(1'b1, 1'b1, 1'b0);
    nb = make_beat(x1, x2, x3, rnd);
    cycle();
    check("post_flush_y1", y1, nb.a);
    check("post_flush_y2", y2, nb.b);
    check("post_flush_y3", y3, nb.c);
    drive_rand(1'b0, 1'b1, 1'b0);
    cycle();

    // Random traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0));
      cycle();
    end

    // Reset in the middle of operation with data held.
    drive_rand(1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_y1", y1, 0);
    check("midrst_y2", y2, 0);
    check("midrst_y3", y3, 0);
    check("midrst_cnt", W'(beat_cnt), 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("midrst_in_ready", W'(in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cycle();
    end

`ifdef SHARE_REFRESH_EN
    // Refresh with known masks.
    drive_rand(1'b0, 1'b1, 1'b0);
    cycle();
    cycle();
    drive(1'b1, 64'hA5A5A5A5_12345678, 64'h0F0F0F0F_DEADBEEF, 64'hCAFEBABE_00FF00FF,
          {64'h1, 64'hFFFF0000FFFF0000}, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("refresh_y1", y1, 64'hA5A5A5A5_12345678 ^ 64'hFFFF0000FFFF0000);
    check("refresh_y2", y2, 64'h0F0F0F0F_DEADBEEF ^ 64'h1);
    check("refresh_y3", y3, 64'hCAFEBABE_00FF00FF ^ 64'hFFFF0000FFFF0000 ^ 64'h1);
    check("refresh_xor", y1 ^ y2 ^ y3,
          64'hA5A5A5A5_12345678 ^ 64'h0F0F0F0F_DEADBEEF ^ 64'hCAFEBABE_00FF00FF);
    cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_prince_ti_share_pipe
